// File: rtl/punc_control.sv
// PUnC LC3 control unit: fetch/decode/execute FSM driving the datapath enables and selects.
// Outputs are a Moore decode of the current state and the opcode in ir[15:12].
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        ldi_reg_ld,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StExec2  = 3'd3;
    localparam logic [2:0] StHalt   = 3'd4;

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpLd   = 4'b0010;
    localparam logic [3:0] OpSt   = 4'b0011;
    localparam logic [3:0] OpJsr  = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpLdr  = 4'b0110;
    localparam logic [3:0] OpStr  = 4'b0111;
    localparam logic [3:0] OpNot  = 4'b1001;
    localparam logic [3:0] OpLdi  = 4'b1010;
    localparam logic [3:0] OpSti  = 4'b1011;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpLea  = 4'b1110;
    localparam logic [3:0] OpTrap = 4'b1111;

    logic [2:0]  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  op;
    logic        unused_ir;

    assign op          = ir[15:12];
    assign unused_ir   = ^{ir[8:6], ir[4:0]};
    assign instr_count = count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = (op == OpTrap) ? StHalt : StExec;
            StExec: begin
                if (op == OpLdi || op == OpSti) begin
                    state_d = StExec2;
                end else begin
                    state_d = StFetch;
                    count_d = count_q + 16'd1;
                end
            end
            StExec2: begin
                state_d = StFetch;
                count_d = count_q + 16'd1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 2'd0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_w_addr_sel    = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        ldi_reg_ld       = 1'b0;
        halted           = 1'b0;
        // Reset overrides the state decode so nothing is written while rst is low.
        if (!rst) begin
            pc_clr = 1'b1;
        end else begin
            case (state_q)
                StFetch: begin
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                end
                StExec: begin
                    case (op)
                        OpAdd, OpAnd, OpNot: begin
                            if (op == OpNot)      alu_sel = 3'd2;
                            else if (op == OpAdd) alu_sel = ir[5] ? 3'd1 : 3'd0;
                            else                  alu_sel = ir[5] ? 3'd4 : 3'd3;
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                        end
                        OpBr: pc_ld = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
                        OpJmp: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                        end
                        OpJsr: begin
                            rf_w_en        = 1'b1;
                            rf_w_data_sel  = 2'd2;
                            rf_w_addr_sel  = 1'b1;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        OpLd, OpLdr: begin
                            mem_r_addr_sel   = (op == OpLd) ? 2'd1 : 2'd2;
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OpLea: begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd3;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        OpSt, OpStr: begin
                            mem_w_en       = 1'b1;
                            mem_w_addr_sel = (op == OpSt) ? 2'd0 : 2'd1;
                            rf_r1_addr_sel = 1'b1;
                        end
                        OpLdi, OpSti: begin
                            mem_r_addr_sel = 2'd1;
                            ldi_reg_ld     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StExec2: begin
                    if (op == OpLdi) begin
                        mem_r_addr_sel   = 2'd3;
                        rf_w_en          = 1'b1;
                        rf_w_data_sel    = 2'd1;
                        cond_ld          = 1'b1;
                        cond_ld_data_sel = 1'b1;
                    end else begin
                        mem_w_en       = 1'b1;
                        mem_w_addr_sel = 2'd2;
                        rf_r1_addr_sel = 1'b1;
                    end
                end
                StHalt:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control: table of per-opcode EXEC/EXEC2 decodes plus reset and halt sequences.
module tb_punc_control;

    typedef struct packed {
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       ldi_reg_ld;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        outs_t       exec;
        logic        two_exec;
        outs_t       exec2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ir = 16'h0;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;
    outs_t       act;
    logic [15:0] instr_count;

    int n_pass = 0;
    int n_checks = 0;

    punc_control dut (
        .clk              (clk),
        .rst              (rst),
        .ir               (ir),
        .n                (n),
        .z                (z),
        .p                (p),
        .mem_w_en         (act.mem_w_en),
        .mem_w_addr_sel   (act.mem_w_addr_sel),
        .mem_w_data_sel   (act.mem_w_data_sel),
        .mem_r_addr_sel   (act.mem_r_addr_sel),
        .rf_w_en          (act.rf_w_en),
        .rf_r0_addr_sel   (act.rf_r0_addr_sel),
        .rf_r1_addr_sel   (act.rf_r1_addr_sel),
        .rf_w_data_sel    (act.rf_w_data_sel),
        .rf_w_addr_sel    (act.rf_w_addr_sel),
        .ir_ld            (act.ir_ld),
        .pc_ld            (act.pc_ld),
        .pc_clr           (act.pc_clr),
        .pc_inc           (act.pc_inc),
        .pc_ld_data_sel   (act.pc_ld_data_sel),
        .alu_sel          (act.alu_sel),
        .cond_ld          (act.cond_ld),
        .cond_ld_data_sel (act.cond_ld_data_sel),
        .ldi_reg_ld       (act.ldi_reg_ld),
        .halted           (act.halted),
        .instr_count      (instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_o(input string name, input outs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %07h want %07h", name, act, exp);
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %04h want %04h", name, got, exp);
    endtask

    vec_t        vecs[$];
    outs_t       e, e2, fetch_o, zero_o, rst_o, halt_o;
    logic [15:0] exp_count;

    task automatic add(input logic [15:0] i, input logic [2:0] f, input outs_t x,
                       input logic two, input outs_t x2);
        vec_t v;
        v.ir = i; v.nzp = f; v.exec = x; v.two_exec = two; v.exec2 = x2;
        vecs.push_back(v);
    endtask

    initial begin
        zero_o  = '0;
        fetch_o = '0; fetch_o.ir_ld = 1'b1; fetch_o.pc_inc = 1'b1;
        rst_o   = '0; rst_o.pc_clr = 1'b1;
        halt_o  = '0; halt_o.halted = 1'b1;

        e = '0; e.alu_sel = 3'd1; e.rf_w_en = 1'b1; e.cond_ld = 1'b1;
        add(16'h1262, 3'b000, e, 1'b0, zero_o);                 // ADD imm
        e.alu_sel = 3'd0; add(16'h1042, 3'b000, e, 1'b0, zero_o); // ADD reg
        e.alu_sel = 3'd4; add(16'h5262, 3'b000, e, 1'b0, zero_o); // AND imm
        e.alu_sel = 3'd3; add(16'h5042, 3'b000, e, 1'b0, zero_o); // AND reg
        e.alu_sel = 3'd2; add(16'h927F, 3'b000, e, 1'b0, zero_o); // NOT
        add(16'h0A05, 3'b010, zero_o, 1'b0, zero_o);            // BRnp, z set
        e = '0; e.pc_ld = 1'b1;
        add(16'h0A05, 3'b100, e, 1'b0, zero_o);                 // BRnp, n set
        add(16'h0405, 3'b010, e, 1'b0, zero_o);                 // BRz, z set
        add(16'h0000, 3'b111, zero_o, 1'b0, zero_o);            // no condition bits
        e = '0; e.pc_ld = 1'b1; e.pc_ld_data_sel = 2'd1;
        add(16'hC1C0, 3'b000, e, 1'b0, zero_o);                 // RET
        e = '0; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd2; e.rf_w_addr_sel = 1'b1;
        e.pc_ld = 1'b1; e.pc_ld_data_sel = 2'd2;
        add(16'h4801, 3'b000, e, 1'b0, zero_o);                 // JSR
        e.pc_ld_data_sel = 2'd1;
        add(16'h4080, 3'b000, e, 1'b0, zero_o);                 // JSRR
        e = '0; e.mem_r_addr_sel = 2'd1; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd1;
        e.cond_ld = 1'b1; e.cond_ld_data_sel = 1'b1;
        add(16'h2205, 3'b000, e, 1'b0, zero_o);                 // LD
        e.mem_r_addr_sel = 2'd2;
        add(16'h6285, 3'b000, e, 1'b0, zero_o);                 // LDR
        e = '0; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd3; e.cond_ld = 1'b1;
        e.cond_ld_data_sel = 1'b1;
        add(16'hE203, 3'b000, e, 1'b0, zero_o);                 // LEA
        e = '0; e.mem_w_en = 1'b1; e.rf_r1_addr_sel = 1'b1;
        add(16'h3205, 3'b000, e, 1'b0, zero_o);                 // ST
        e.mem_w_addr_sel = 2'd1;
        add(16'h7285, 3'b000, e, 1'b0, zero_o);                 // STR
        e = '0; e.mem_r_addr_sel = 2'd1; e.ldi_reg_ld = 1'b1;
        e2 = '0; e2.mem_r_addr_sel = 2'd3; e2.rf_w_en = 1'b1; e2.rf_w_data_sel = 2'd1;
        e2.cond_ld = 1'b1; e2.cond_ld_data_sel = 1'b1;
        add(16'hA003, 3'b000, e, 1'b1, e2);                     // LDI
        e2 = '0; e2.mem_w_en = 1'b1; e2.mem_w_addr_sel = 2'd2; e2.rf_r1_addr_sel = 1'b1;
        add(16'hB003, 3'b000, e, 1'b1, e2);                     // STI
        add(16'h8000, 3'b000, zero_o, 1'b0, zero_o);            // 1000 no-op
        add(16'hD000, 3'b000, zero_o, 1'b0, zero_o);            // 1101 no-op

        // Reset held three cycles.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_o("reset_outs", rst_o);
        chk16("reset_count", instr_count, 16'd0);
        rst = 1'b1;
        #1;
        chk_o("first_fetch", fetch_o);
        exp_count = 16'd0;

        foreach (vecs[k]) begin
            chk_o($sformatf("fetch_%0d", k), fetch_o);
            ir = vecs[k].ir;
            {n, z, p} = vecs[k].nzp;
            step();
            chk_o($sformatf("decode_%04h", vecs[k].ir), zero_o);
            step();
            chk_o($sformatf("exec_%04h_nzp%03b", vecs[k].ir, vecs[k].nzp), vecs[k].exec);
            step();
            if (vecs[k].two_exec) begin
                chk_o($sformatf("exec2_%04h", vecs[k].ir), vecs[k].exec2);
                step();
            end
            exp_count = exp_count + 16'd1;
            chk16($sformatf("count_after_%04h", vecs[k].ir), instr_count, exp_count);
        end
        {n, z, p} = 3'b000;

        // Reset in the middle of an ADD aborts it with no writes.
        ir = 16'h1262;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_o("midreset_outs", rst_o);
        chk16("midreset_count", instr_count, 16'd0);
        step();
        rst = 1'b1;
        #1;
        chk_o("midreset_refetch", fetch_o);

        // TRAP halts two cycles after its fetch and stays there.
        ir = 16'hF025;
        step();
        chk_o("halt_decode", zero_o);
        step();
        for (int i = 0; i < 20; i++) begin
            chk_o($sformatf("halt_cycle_%0d", i), halt_o);
            step();
        end
        chk16("halt_count", instr_count, 16'd0);
        rst = 1'b0;
        #1;
        chk_o("halt_reset", rst_o);
        step();
        rst = 1'b1;
        #1;
        chk_o("halt_refetch", fetch_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/punc_control.md
# punc_control

Control unit for the PUnC LC3 processor and the counterpart of the PUnC datapath. It runs a fetch/decode/execute state machine, reads `ir` and the n/z/p condition codes from the datapath, and drives every datapath enable and mux select. It sits beside the datapath inside the PUnC top level and owns instruction sequencing, branch resolution and halt.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- ir  in  16  instruction register from the datapath.
- n, z, p  in  1 each  condition codes.
- mem_w_en  out  1  memory write enable.
- mem_w_addr_sel  out  2  0=PC+sext9, 1=r0_data+sext6, 2=LDI temp.
- mem_w_data_sel  out  1  0=r1_data, 1=mem read data.
- mem_r_addr_sel  out  2  0=PC, 1=PC+sext9, 2=r0_data+sext6, 3=LDI temp.
- rf_w_en  out  1  register file write enable.
- rf_r0_addr_sel  out  1  0=ir[8:6], 1=ir[11:9].
- rf_r1_addr_sel  out  1  0=ir[2:0], 1=ir[11:9].
- rf_w_data_sel  out  2  0=ALU, 1=mem, 2=PC, 3=PC+sext9.
- rf_w_addr_sel  out  1  0=ir[11:9], 1=R7.
- ir_ld  out  1  load IR from the memory read port.
- pc_ld, pc_clr, pc_inc  out  1 each  PC load/clear/increment.
- pc_ld_data_sel  out  2  0=PC+sext9, 1=r0_data, 2=PC+sext11; PC is loaded with this value directly.
- alu_sel  out  3  0=ADD, 1=ADDI, 2=NOT, 3=AND, 4=ANDI, 5=PASS.
- cond_ld  out  1  load n/z/p.
- cond_ld_data_sel  out  1  0=ALU out, 1=RF write data.
- ldi_reg_ld  out  1  capture mem read data into the LDI temp register.
- halted  out  1  high while in HALT.
- instr_count  out  16  number of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, EXEC2, HALT. Reset enters FETCH.
- Outputs are a Moore decode of state and `ir[15:12]`. Any output not listed for a state is 0.
- **FETCH**: mem_r_addr_sel=0, ir_ld=1, pc_inc=1. Next state is DECODE.
- **DECODE**: no enables. Next state is HALT when the opcode is 1111 (TRAP), otherwise EXEC.
- **EXEC** uses the already-incremented PC. Behaviour per opcode:
  - ADD 0001 / AND 0101: alu_sel = ir[5] ? ADDI/ANDI : ADD/AND; r0 sel 0, r1 sel 0; rf_w_en=1, w_data 0, w_addr 0; cond_ld=1, cond sel 0.
  - NOT 1001: alu_sel=2, otherwise the same as ADD.
  - BR 0000: pc_ld = (ir[11]&n)|(ir[10]&z)|(ir[9]&p), pc_ld_data_sel=0.
  - JMP/RET 1100: pc_ld=1, sel 1, r0 sel 0.
  - JSR 0100:
    - rf_w_en=1, w_data 2, w_addr 1 (R7 receives the pre-jump PC).
    - pc_ld=1 with sel 2 if ir[11]; otherwise sel 1 with r0 sel 0.
    - R7 as BaseR reads the old R7.
  - LD 0010 / LDR 0110: mem_r_addr_sel 1 or 2 (r0 sel 0); rf_w_en, w_data 1, w_addr 0; cond_ld, sel 1.
  - LEA 1110: rf_w_en, w_data 3, w_addr 0; cond_ld, sel 1.
  - ST 0011: mem_w_en, w_addr sel 0, w_data sel 0, r1 sel 1.
  - STR 0111: mem_w_en, w_addr sel 1, r0 sel 0, r1 sel 1.
  - LDI 1010 / STI 1011: mem_r_addr_sel=1, ldi_reg_ld=1. Next state is EXEC2.
  - 1000 and 1101: no-op.
- **EXEC2**:
  - LDI: mem_r_addr_sel=3, rf_w_en, w_data 1, w_addr 0, cond_ld sel 1.
  - STI: mem_w_en, w_addr sel 2, w_data sel 0, r1 sel 1.
- Leaving EXEC or EXEC2 returns to FETCH and increments instr_count, which wraps 0xFFFF→0.
- **HALT**: absorbing. halted=1 and all enables are 0 until reset.

## Timing
- While rst=0: state=FETCH, instr_count=0, halted=0. Outputs are the FETCH decode gated to 0: pc_clr=1, all other enables 0.
- First FETCH occurs on the first rising edge after rst deasserts.
- Reset asserted mid-instruction aborts it immediately, with no further writes.
- Latency per instruction class:
  - 3 cycles for most instructions.
  - 4 cycles for LDI/STI.
  - HALT is reached 2 cycles after its fetch.
- Each state lasts exactly one cycle, with no stalls.
- Only one of pc_ld/pc_inc/pc_clr is asserted in any cycle.
- instr_count updates on the same edge that enters FETCH.

## Test plan
- Reset held 3 cycles, then released → ir_ld=1 and pc_inc=1 in the first cycle; instr_count=0; pc_clr=1 only during reset.
- ir=0x1262 (ADD R1,R1,#2) → sequence FETCH, DECODE, EXEC; alu_sel=1, rf_w_en=1, cond_ld=1; instr_count=1.
- ir=0x0A05 (BRnp) with z=1 → pc_ld=0. The same instruction with n=1 → pc_ld=1, sel 0.
- ir=0xA003 (LDI) → EXEC: ldi_reg_ld=1, mem_r_addr_sel=1. EXEC2: mem_r_addr_sel=3, rf_w_en=1. 4 cycles total.
- ir=0x4801 (JSR) → rf_w_en=1, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld=1, pc_ld_data_sel=2 in the same cycle.
- ir=0xF025 (HALT) → halted=1 from the third cycle; no enables for 20 cycles; rst=0 returns to FETCH.
